dual_core_ram_arbiter: RTL and testbench
========================================

// Module: dual_core_ram_arbiter
// PURPOSE
//   Shares one single-port data RAM between the two processor cores of the dual-core top.
//   Each core issues req/we/addr/wdata; the arbiter serialises accesses round-robin,
//   drives the RAM port and returns a grant strobe, plus read data with a valid strobe.
//   Sits between the cores' RAM ports (ram_en/addr/ram_in/ram_out) and the shared RAM.
// PARAMETERS
//   DW  32  data width of RAM words and core read/write data
//   AW   8  RAM address width
// PORTS
//   clk        in   1   single system clock, all logic on rising edge
//   rst        in   1   synchronous, active-high reset
//   req0       in   1   core 0 access request; held with we0/addr0/wdata0 stable until gnt0
//   we0        in   1   core 0 write enable (1=write, 0=read)
//   addr0      in   AW  core 0 address
//   wdata0     in   DW  core 0 write data
//   gnt0       out  1   one-cycle pulse: core 0 access issued to RAM this cycle
//   rvalid0    out  1   one-cycle pulse: rdata0 holds core 0 read result
//   rdata0     out  DW  core 0 read data, held until next core 0 read completes
//   req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1   same as above for core 1
//   mem_en     out  1   RAM access enable
//   mem_we     out  1   RAM write enable
//   mem_addr   out  AW  RAM address
//   mem_wdata  out  DW  RAM write data
//   mem_rdata  in   DW  RAM read data, valid 1 cycle after mem_en with mem_we=0
//   busy       out  1   high whenever FSM is not IDLE
// BEHAVIOUR
//   Reset: FSM=IDLE; gnt*, rvalid*, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, rdata* = 0;
//     rr pointer last=1, so core 0 wins the first conflict.
//   FSM states: IDLE, ACCESS, RESP.
//   IDLE: samples req0/req1. None -> stay. One -> that core wins. Both -> core != last wins.
//     On a win, register winner, we, addr, wdata into the mem_* outputs; go to ACCESS.
//   ACCESS: mem_en=1 with the registered command; gnt<winner>=1; last<=winner.
//     Write -> IDLE. Read -> RESP.
//   RESP: capture mem_rdata into rdata<winner>; rvalid<winner>=1 in the next cycle (IDLE).
//     The loser's rdata and rvalid are unaffected.
//   Latency from req sampled in IDLE: gnt at +1 cycle; rvalid at +3 cycles.
//   Throughput: write 2 cycles/access, read 3 cycles/access.
//   mem_en and gnt* are high only in ACCESS; mem_we=0 outside ACCESS.
//   Handshake: requester holds req and the command until it sees gnt, then drops req or
//     presents a new command. A req still high after gnt is a new request.
//   Boundaries:
//     - A req that drops before grant is ignored; no grant is issued.
//     - Both cores at the same address: serialised in round-robin order. Within the
//       arbiter, no write-read forwarding is needed beyond RAM ordering.
//     - Continuous requests from both cores: strict alternation, no starvation.
//     - rst in ACCESS or RESP: immediate return to reset state; the in-flight read
//       produces no rvalid; a write already on mem_en is not retracted.
//     - Cores run from the same clk and rst; no clock-domain crossing.
// CONFIGURATION
//   ARB_STATS_EN defined: adds output ports gcnt0, gcnt1 (16 bit, grants per core) and
//     ccnt (16 bit, IDLE cycles with both req high). All three saturate at 0xFFFF and
//     clear on rst.
//   ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour
//     is identical.
// TESTING
//   1. req0 only, write addr=0x10 data=0xDEADBEEF -> gnt0 at +1; mem_we=1, mem_addr=0x10; no rvalid.
//   2. req0 read addr=0x10 after test 1 -> rvalid0 at +3 with rdata0=0xDEADBEEF; rdata1 unchanged.
//   3. req0 and req1 both high from reset, both reads -> gnt0 first, then gnt1;
//      rvalid0 precedes rvalid1.
//   4. Both reqs held high for 8 grants -> grants alternate 0,1,0,1...; with ARB_STATS_EN,
//      gcnt0=gcnt1=4.
//   5. rst asserted in RESP of a core1 read -> rvalid1 never pulses; all outputs are 0 the
//      next cycle.
//   6. req1 pulses for 1 cycle while FSM busy with core 0 -> no gnt1 issued.

Source files
------------

// File: rtl/dual_core_ram_arbiter.sv
// ============================================================================
// Module   : dual_core_ram_arbiter
// Brief    : Round-robin arbiter sharing one single-port data RAM between two
//            processor cores. It serialises req/we/addr/wdata commands onto the
//            RAM port, pulses a grant per issued access and returns read data
//            with a valid strobe.
// Options  : ARB_STATS_EN - adds 16-bit saturating statistics outputs
//            gcnt0/gcnt1 (grants per core) and ccnt (conflict cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_core_ram_arbiter #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  // core 0
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // core 1
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  // shared RAM port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1,
  output logic [15:0]   ccnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0] state;
  logic       last;     // core granted most recently; the other one wins a tie
  logic       win;      // core owning the access in flight
  logic       cmd_we;   // registered write flag of the access in flight
  logic       pick1;    // IDLE-cycle arbitration result: 1 selects core 1

  // Round-robin choice: a lone requester wins, a tie goes to the core that was not last served
  always_comb begin
    pick1 = req1;
    if (req0 && req1) begin
      pick1 = ~last;
    end
  end

  // Main FSM: latch the winning command, issue it, then collect read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      cmd_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            win       <= pick1;
            cmd_we    <= pick1 ? we1    : we0;
            mem_addr  <= pick1 ? addr1  : addr0;
            mem_wdata <= pick1 ? wdata1 : wdata0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          last  <= win;
          state <= cmd_we ? S_IDLE : S_RESP;
        end
        S_RESP: begin
          // RAM read data is valid in the cycle after mem_en
          if (win) begin
            rdata1  <= mem_rdata;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_rdata;
            rvalid0 <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes and grants are pure decodes of the ACCESS state
  always_comb begin
    mem_en = (state == S_ACCESS);
    mem_we = mem_en & cmd_we;
    gnt0   = mem_en & ~win;
    gnt1   = mem_en & win;
    busy   = (state != S_IDLE);
  end

`ifdef ARB_STATS_EN
  // Saturating statistics: grants per core and IDLE cycles with a conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
      ccnt  <= '0;
    end else begin
      if (gnt0 && (gcnt0 != 16'hFFFF)) gcnt0 <= gcnt0 + 16'd1;
      if (gnt1 && (gcnt1 != 16'hFFFF)) gcnt1 <= gcnt1 + 16'd1;
      if ((state == S_IDLE) && req0 && req1 && (ccnt != 16'hFFFF)) ccnt <= ccnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_core_ram_arbiter.sv
// ============================================================================
// Module   : tb_dual_core_ram_arbiter
// Brief    : Directed self-checking bench for dual_core_ram_arbiter with a
//            behavioural RAM, a reference memory and per-core read scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_core_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  mem_addr;
`ifdef ARB_STATS_EN
  logic [15:0] gcnt0, gcnt1, ccnt;
`endif

  dual_core_ram_arbiter #(.DW(32), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1), .ccnt(ccnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle read latency
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          gnt_log[$];
  int          rv_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample #1 after the edge, log grants and score read returns
  task automatic step();
    @(posedge clk);
    #1;
    if (gnt0) gnt_log.push_back(0);
    if (gnt1) gnt_log.push_back(1);
    if (gnt0 || gnt1) check("gnt_exclusive", {63'd0, gnt0 & gnt1}, 64'd0);
    if (rvalid0) begin
      rv_log.push_back(0);
      check("rvalid0_expected", {63'd0, exp0.size() != 0}, 64'd1);
      if (exp0.size() != 0) check("rdata0", {32'd0, rdata0}, {32'd0, exp0.pop_front()});
    end
    if (rvalid1) begin
      rv_log.push_back(1);
      check("rvalid1_expected", {63'd0, exp1.size() != 0}, 64'd1);
      if (exp1.size() != 0) check("rdata1", {32'd0, rdata1}, {32'd0, exp1.pop_front()});
    end
  endtask

  task automatic drive(input int core, input logic req, input logic we,
                       input logic [7:0] a, input logic [31:0] d);
    if (core == 0) begin
      req0 = req; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = req; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    gnt_log.delete();
    rv_log.delete();
  endtask

  // One isolated access from an IDLE arbiter, checking grant and read latency
  task automatic access(input int core, input logic we, input logic [7:0] a, input logic [31:0] d);
    int   n;
    logic g;
    if (we) ref_mem[a] = d;
    else if (core == 0) exp0.push_back(ref_mem[a]);
    else exp1.push_back(ref_mem[a]);
    drive(core, 1'b1, we, a, d);
    n = 0;
    g = 1'b0;
    while (!g && n < 10) begin
      step();
      n++;
      g = (core == 0) ? gnt0 : gnt1;
    end
    check("gnt_latency", 64'(n), 64'd1);
    check("mem_addr", {56'd0, mem_addr}, {56'd0, a});
    check("mem_we", {63'd0, mem_we}, {63'd0, we});
    if (we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, d});
    drive(core, 1'b0, 1'b0, 8'h00, 32'h0);
    if (we) begin
      step();
      check("no_rvalid_after_write", {62'd0, rvalid0, rvalid1}, 64'd0);
      check("idle_after_write", {63'd0, busy}, 64'd0);
    end else begin
      step();
      check("rvalid_not_at_+2", {63'd0, (core == 0) ? rvalid0 : rvalid1}, 64'd0);
      step();
      check("rvalid_at_+3", {63'd0, (core == 0) ? rvalid0 : rvalid1}, 64'd1);
    end
  endtask

  initial begin : main
    int n;
    int cnt;

    // ---- reset state ----
    do_reset();
    check("reset_strobes", {57'd0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}, 64'd0);
    check("reset_mem_addr", {56'd0, mem_addr}, 64'd0);
    check("reset_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("reset_rdata", {rdata0, rdata1}, 64'd0);

    // ---- test 1: core 0 write, plus a core 1 write for later reads ----
    access(0, 1'b1, 8'h10, 32'hDEADBEEF);
    access(1, 1'b1, 8'h20, 32'h12345678);

    // ---- test 2: core 0 read back; core 1 read data untouched ----
    access(0, 1'b0, 8'h10, 32'h0);
    check("rdata1_unchanged", {32'd0, rdata1}, 64'd0);

    // ---- test 3: simultaneous reads from reset ----
    do_reset();
    exp0.push_back(ref_mem[8'h10]);
    exp1.push_back(ref_mem[8'h20]);
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h20, 32'h0);
    n = 0;
    while (rv_log.size() < 2 && n < 20) begin
      step();
      n++;
      if (gnt0) drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
      if (gnt1) drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    end
    check("t3_grant_count", 64'(gnt_log.size()), 64'd2);
    check("t3_rvalid_count", 64'(rv_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      check("t3_first_grant", 64'(gnt_log[0]), 64'd0);
      check("t3_second_grant", 64'(gnt_log[1]), 64'd1);
    end
    if (rv_log.size() == 2) check("t3_rvalid_order", 64'(rv_log[0]), 64'd0);

    // ---- test 4: both cores request continuously, 8 write grants ----
    do_reset();
    ref_mem[8'h30] = 32'hA0A0A0A0;
    ref_mem[8'h31] = 32'hB1B1B1B1;
    drive(0, 1'b1, 1'b1, 8'h30, 32'hA0A0A0A0);
    drive(1, 1'b1, 1'b1, 8'h31, 32'hB1B1B1B1);
    n = 0;
    while (gnt_log.size() < 8 && n < 60) begin
      step();
      n++;
    end
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    check("t4_grant_count", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < gnt_log.size(); i++) begin
      check($sformatf("t4_alternation_%0d", i), 64'(gnt_log[i]), 64'(i % 2));
    end
    step();
`ifdef ARB_STATS_EN
    check("t4_gcnt0", {48'd0, gcnt0}, 64'd4);
    check("t4_gcnt1", {48'd0, gcnt1}, 64'd4);
    check("t4_ccnt", {48'd0, ccnt}, 64'd8);
`endif
    access(0, 1'b0, 8'h31, 32'h0);

    // ---- test 5: reset during RESP of a core 1 read ----
    rv_log.delete();
    drive(1, 1'b1, 1'b0, 8'h20, 32'h0);
    n = 0;
    while (!gnt1 && n < 10) begin
      step();
      n++;
    end
    check("t5_gnt1_seen", {63'd0, gnt1}, 64'd1);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    check("t5_in_resp_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    step();
    check("t5_outputs_cleared", {57'd0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}, 64'd0);
    check("t5_data_cleared", {rdata0, rdata1}, 64'd0);
    check("t5_mem_addr_cleared", {56'd0, mem_addr}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t5_no_rvalid", 64'(rv_log.size()), 64'd0);

    // ---- test 6: one-cycle core 1 pulse while core 0 is being served ----
    gnt_log.delete();
    exp0.push_back(ref_mem[8'h10]);
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0);
    n = 0;
    while (!gnt0 && n < 10) begin
      step();
      n++;
    end
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h20, 32'h0);
    step();
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) step();
    cnt = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == 1) cnt++;
    check("t6_no_gnt1", 64'(cnt), 64'd0);
    check("t6_core0_read_returned", 64'(exp0.size()), 64'd0);
    check("t6_idle_at_end", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
